lfsr_gen: RTL

- Parametrised Fibonacci LFSR; successor to the fixed 4-bit LFSR.
- Configurable width and tap mask.
- Adds step enable, runtime seed load, all-zero lockup recovery, and sequence-wrap detection with period measurement.
- Serves as a pseudo-random source and self-checking sequence generator for test and scrambler logic.

---
 rtl/lfsr_gen_if.sv | 37 +++
 rtl/lfsr_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and observation bundle for the LFSR generator.
// The master side owns step/load control; the slave side (the generator)
// drives the state, the serial bit, the event pulses and the period.
interface lfsr_gen_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic             bit_out;
   logic             wrap;
   logic             lockup;
   logic [WIDTH-1:0] period;

   modport master (
      output en,
      output load,
      output load_val,
      input  out,
      input  bit_out,
      input  wrap,
      input  lockup,
      input  period
   );

   modport slave (
      input  en,
      input  load,
      input  load_val,
      output out,
      output bit_out,
      output wrap,
      output lockup,
      output period
   );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with step enable, runtime seed
// load, all-zero lockup recovery and wrap detection with period measurement.
// The state shifts left and the XOR of the tapped bits enters bit 0.
module lfsr_gen #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
   parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
   input logic       clk,
   input logic       rst,
   lfsr_gen_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Parameter sanity: a zero seed would lock the generator up forever,
   // and without the top tap the register degenerates into a shorter LFSR.
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 2..32");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be nonzero");
   end
   if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
      $error("lfsr_gen: TAPS bit WIDTH-1 must be set");
   end

   // Architectural state.
   logic [WIDTH-1:0] state_q;   // current LFSR value
   logic [WIDTH-1:0] ref_q;     // value whose recurrence marks a completed cycle
   logic [WIDTH-1:0] cnt_q;     // steps since ref_q was last left/reached
   logic [WIDTH-1:0] period_q;  // length of the last completed cycle
   logic             wrap_q;
   logic             lockup_q;

   // Next-state values.
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] ref_d;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] period_d;
   logic             wrap_d;
   logic             lockup_d;

   // Datapath helpers.
   logic             fb;
   logic [WIDTH-1:0] step_val;
   logic             is_zero;
   logic             hit_ref;

   // Feedback and one-step successor of the current state.
   always_comb begin
      fb       = ^(state_q & TAPS);
      step_val = {state_q[WIDTH-2:0], fb};
      is_zero  = (state_q == '0);
      hit_ref  = (step_val == ref_q);
   end

   // Per-edge priority below reset: load, then lockup recovery, then step,
   // otherwise hold. Pulses default low so they last exactly one cycle.
   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;
      if (bus.load) begin
         // A load restarts period measurement from the loaded value; a zero
         // load is accepted and recovered from on the following edge.
         state_d = bus.load_val;
         ref_d   = bus.load_val;
         cnt_d   = '0;
      end else if (is_zero) begin
         // Recovery ignores en so a stalled generator never stays stuck.
         state_d  = SEED;
         ref_d    = SEED;
         cnt_d    = '0;
         lockup_d = 1'b1;
      end else if (bus.en) begin
         state_d = step_val;
         if (hit_ref) begin
            wrap_d   = 1'b1;
            period_d = cnt_q + ONE;
            cnt_d    = '0;
         end else begin
            // Non-maximal taps may overflow this; it simply wraps.
            cnt_d = cnt_q + ONE;
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= SEED;
         ref_q    <= SEED;
         cnt_q    <= '0;
         period_q <= '0;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   // Outputs are straight from registers, so pulses align with out.
   assign bus.out     = state_q;
   assign bus.bit_out = state_q[WIDTH-1];
   assign bus.wrap    = wrap_q;
   assign bus.lockup  = lockup_q;
   assign bus.period  = period_q;

endmodule
